rom_msg_sender: RTL and testbench

//  Downstream consumer of the 16x8 synchronous character ROM. On start, walks ROM

---
 rtl/rom_msg_sender_pkg.sv | 21 ++
 rtl/rom_msg_sender_if.sv | 34 +++
 rtl/rom_msg_sender.sv | 119 +++++++++++
 tb/tb_rom_msg_sender.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_msg_sender_pkg.sv
// rtl/rom_msg_sender_pkg.sv - shared FSM encoding and ASCII constants for the ROM message sender
// Build option: ROM_MSG_CRLF_EN adds the SEND_CR/SEND_LF states to the encoding.
package rom_msg_sender_pkg;

  localparam logic [7:0] ASCII_CR          = 8'h0D;
  localparam logic [7:0] ASCII_LF          = 8'h0A;
  localparam logic [7:0] DEFAULT_TERM_CHAR = 8'h30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
`ifdef ROM_MSG_CRLF_EN
    S_SEND_CR,
    S_SEND_LF,
`endif
    S_END
  } state_t;

endpackage

// File: rtl/rom_msg_sender_if.sv
// rtl/rom_msg_sender_if.sv - ROM address/data bus plus transmitter valid/ready stream
// Signals:
//   rom_address  address presented to the synchronous ROM
//   rom_data     ROM output, valid one cycle after the address is registered
//   tx_data      character offered to the transmitter
//   tx_valid     tx_data valid
//   tx_ready     transmitter accepts; transfer = tx_valid & tx_ready at posedge
// master = message sender, slave = ROM + transmitter side.
interface rom_msg_sender_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output rom_address,
    input  rom_data,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  rom_address,
    output rom_data,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/rom_msg_sender.sv
// rtl/rom_msg_sender.sv - walks the character ROM from address 0 and streams bytes to the UART TX
// Ports:
//   clock   system clock, all logic on posedge
//   reset   synchronous, active-high; aborts any message in flight
//   start   request to send the message, sampled only in IDLE
//   busy    high in every state except IDLE
//   done    one-cycle pulse when the message is complete
//   bus     master side of rom_msg_sender_if (ROM address/data, tx stream)
// Build option: ROM_MSG_CRLF_EN appends CR LF after the last data byte.
module rom_msg_sender
  import rom_msg_sender_pkg::*;
#(
  parameter int              ADDR_W    = 4,
  parameter int              DATA_W    = 8,
  parameter int              MAX_LEN   = 16,
  parameter logic [DATA_W-1:0] TERM_CHAR = DATA_W'(DEFAULT_TERM_CHAR)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  rom_msg_sender_if.master  bus
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic              tx_valid;
  logic              xfer;
  logic              last_addr;
  logic              msg_end;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state  <= state_n;
      addr_q <= addr_n;
      data_q <= data_n;
    end
  end

`ifdef ROM_MSG_CRLF_EN
  assign tx_valid = (state == S_SEND) || (state == S_SEND_CR) || (state == S_SEND_LF);
`else
  assign tx_valid = (state == S_SEND);
`endif

  assign xfer      = tx_valid & bus.tx_ready;
  assign last_addr = (addr_q == ADDR_W'(MAX_LEN - 1));

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    data_n  = data_q;
    msg_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_FETCH;
          addr_n  = '0;
        end
      end
      // Address is already registered; this edge lets the ROM capture it.
      S_FETCH: state_n = S_LOAD;
      S_LOAD: begin
        if (bus.rom_data == TERM_CHAR) begin
          msg_end = 1'b1;
        end else begin
          data_n  = bus.rom_data;
          state_n = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (last_addr) begin
            msg_end = 1'b1;
          end else begin
            addr_n  = addr_q + 1'b1;
            state_n = S_FETCH;
          end
        end
      end
`ifdef ROM_MSG_CRLF_EN
      S_SEND_CR: begin
        if (xfer) begin
          data_n  = DATA_W'(ASCII_LF);
          state_n = S_SEND_LF;
        end
      end
      S_SEND_LF: begin
        if (xfer) state_n = S_END;
      end
`endif
      S_END:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Terminator and length limit share one exit path, optionally via CR LF.
    if (msg_end) begin
`ifdef ROM_MSG_CRLF_EN
      data_n  = DATA_W'(ASCII_CR);
      state_n = S_SEND_CR;
`else
      state_n = S_END;
`endif
    end
  end

  assign bus.rom_address = addr_q;
  assign bus.tx_data     = data_q;
  assign bus.tx_valid    = tx_valid;
  assign busy            = (state != S_IDLE);
  assign done            = (state == S_END);

endmodule

// File: tb/tb_rom_msg_sender.sv
// tb/tb_rom_msg_sender.sv - directed self-checking bench for rom_msg_sender
module tb_rom_msg_sender;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;
  logic [7:0] rom [16];
  logic [7:0] rom_q;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] byte_q [$];
  int         done_cnt;
  int         max_addr;
  bit         valid_seen;

  always #5 clock = ~clock;

  rom_msg_sender_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  rom_msg_sender dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus.master)
  );

  always @(posedge clock) rom_q <= rom[bus.rom_address];
  assign bus.rom_data = rom_q;

  // Inputs only move at posedge+1, so the falling edge sees settled values.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.tx_valid && bus.tx_ready) byte_q.push_back(bus.tx_data);
      if (bus.tx_valid) valid_seen = 1'b1;
      if (done) done_cnt++;
      if (int'(bus.rom_address) > max_addr) max_addr = int'(bus.rom_address);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    byte_q.delete();
    done_cnt   = 0;
    max_addr   = 0;
    valid_seen = 1'b0;
  endtask

  task automatic load_basic();
    logic [127:0] msg;
    msg = "VERILOGUEA000000";
    for (int i = 0; i < 16; i++) rom[i] = msg[127-8*i -: 8];
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic basic_expect(output logic [7:0] exp [$]);
    exp = '{8'h56, 8'h45, 8'h52, 8'h49, 8'h4C, 8'h4F, 8'h47, 8'h55, 8'h45, 8'h41};
`ifdef ROM_MSG_CRLF_EN
    exp.push_back(8'h0D);
    exp.push_back(8'h0A);
`endif
  endtask

  task automatic check_stream(input string name, input logic [7:0] exp [$]);
    total_cnt++;
    if (byte_q.size() !== exp.size())
      $display("FAIL %s_len got %0d exp %0d", name, byte_q.size(), exp.size());
    else pass_cnt++;
    for (int i = 0; i < exp.size(); i++) begin
      total_cnt++;
      if (i >= byte_q.size())
        $display("FAIL %s[%0d] got none exp %02h", name, i, exp[i]);
      else if (byte_q[i] !== exp[i])
        $display("FAIL %s[%0d] got %02h exp %02h", name, i, byte_q[i], exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bus.tx_ready = 1'b1;
    load_basic();
    repeat (3) tick();
    total_cnt++; if (bus.tx_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus.tx_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else pass_cnt++;
    total_cnt++; if (bus.rom_address !== 4'd0) $display("FAIL rst_addr got %0d exp 0", bus.rom_address); else pass_cnt++;
    total_cnt++; if (bus.tx_data !== 8'h00) $display("FAIL rst_data got %02h exp 00", bus.tx_data); else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp [$];
    bit ok;
    basic_expect(exp);
    load_basic();
    clear_mon();
    pulse_start();
    total_cnt++; if (bus.tx_valid !== 1'b0) $display("FAIL lat_fetch_valid got %b exp 0", bus.tx_valid); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (bus.tx_valid !== 1'b1) $display("FAIL lat_send_valid got %b exp 1", bus.tx_valid); else pass_cnt++;
    total_cnt++; if (bus.tx_data !== 8'h56) $display("FAIL lat_send_data got %02h exp 56", bus.tx_data); else pass_cnt++;
    wait_done(200, ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL basic_done_timeout got %b exp 1", ok); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_after got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); else pass_cnt++;
    check_stream("basic", exp);
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [$];
    bit ok;
    bit found;
    basic_expect(exp);
    load_basic();
    clear_mon();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.tx_valid && bus.tx_data == 8'h52) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total_cnt++; if (found !== 1'b1) $display("FAIL bp_third_byte got %b exp 1", found); else pass_cnt++;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++; if (bus.tx_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b exp 1", i, bus.tx_valid); else pass_cnt++;
      total_cnt++; if (bus.tx_data !== 8'h52) $display("FAIL bp_data[%0d] got %02h exp 52", i, bus.tx_data); else pass_cnt++;
    end
    bus.tx_ready = 1'b1;
    wait_done(200, ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL bp_done_timeout got %b exp 1", ok); else pass_cnt++;
    tick();
    check_stream("bp", exp);
  endtask

  task automatic test_no_term();
    logic [7:0] exp [$];
    bit ok;
    for (int i = 0; i < 16; i++) rom[i] = 8'h41;
    exp.delete();
    for (int i = 0; i < 16; i++) exp.push_back(8'h41);
`ifdef ROM_MSG_CRLF_EN
    exp.push_back(8'h0D);
    exp.push_back(8'h0A);
`endif
    clear_mon();
    pulse_start();
    wait_done(300, ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL maxlen_done_timeout got %b exp 1", ok); else pass_cnt++;
    tick();
    total_cnt++; if (max_addr !== 15) $display("FAIL maxlen_max_addr got %0d exp 15", max_addr); else pass_cnt++;
    total_cnt++; if (bus.rom_address !== 4'd15) $display("FAIL maxlen_addr_end got %0d exp 15", bus.rom_address); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL maxlen_done_cnt got %0d exp 1", done_cnt); else pass_cnt++;
    check_stream("maxlen", exp);
  endtask

  task automatic test_zero_len_and_restart();
    logic [7:0] exp [$];
    bit ok;
    load_basic();
    rom[0] = 8'h30;
    clear_mon();
    pulse_start();
`ifdef ROM_MSG_CRLF_EN
    wait_done(50, ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL zero_done_timeout got %b exp 1", ok); else pass_cnt++;
    tick();
    exp = '{8'h0D, 8'h0A};
    check_stream("zero", exp);
`else
    tick();
    total_cnt++; if (done !== 1'b0) $display("FAIL zero_done_early got %b exp 0", done); else pass_cnt++;
    tick();
    total_cnt++; if (done !== 1'b1) $display("FAIL zero_done_at_end got %b exp 1", done); else pass_cnt++;
    tick();
    total_cnt++; if (valid_seen !== 1'b0) $display("FAIL zero_valid_seen got %b exp 0", valid_seen); else pass_cnt++;
`endif
    total_cnt++; if (done_cnt !== 1) $display("FAIL zero_done_cnt got %0d exp 1", done_cnt); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL zero_busy got %b exp 0", busy); else pass_cnt++;

    // start held high for several cycles mid-message must not disturb it
    load_basic();
    basic_expect(exp);
    clear_mon();
    pulse_start();
    repeat (6) tick();
    start = 1'b1;
    repeat (4) tick();
    start = 1'b0;
    wait_done(200, ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL midstart_done_timeout got %b exp 1", ok); else pass_cnt++;
    tick();
    total_cnt++; if (done_cnt !== 1) $display("FAIL midstart_done_cnt got %0d exp 1", done_cnt); else pass_cnt++;
    check_stream("midstart", exp);
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [$];
    bit ok;
    bit found;
    basic_expect(exp);
    load_basic();
    clear_mon();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.tx_valid && bus.tx_data == 8'h49) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total_cnt++; if (found !== 1'b1) $display("FAIL rmid_fourth_byte got %b exp 1", found); else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++; if (bus.tx_valid !== 1'b0) $display("FAIL rmid_valid got %b exp 0", bus.tx_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (bus.rom_address !== 4'd0) $display("FAIL rmid_addr got %0d exp 0", bus.rom_address); else pass_cnt++;
    clear_mon();
    pulse_start();
    wait_done(200, ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL rmid_done_timeout got %b exp 1", ok); else pass_cnt++;
    tick();
    check_stream("rmid", exp);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_no_term();
    test_zero_len_and_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
